// File: rtl/ecdsa_ugen.sv
// ECDSA verify scalar stage: u1 = e*w mod N and u2 = r*w mod N.
// A single bit-serial interleaved modular multiplier is shared by both products.
module ecdsa_ugen #(
  parameter int W = 256,
  parameter logic [W-1:0] N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] e,
  input  logic [W-1:0] r,
  input  logic [W-1:0] w,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] u1,
  output logic [W-1:0] u2
);

  localparam int CW = $clog2(W);
  localparam logic [W:0] NX = {1'b0, N};

  typedef enum logic [2:0] {IDLE, CHECK, MUL1, MUL2, DONE} state_t;

  state_t        state;
  logic [W-1:0]  e_q, r_q, w_q, acc;
  logic [CW-1:0] cnt;

  logic [W-1:0] a, e_red, acc_next;
  logic [W:0]   t1, t1r, t2, t2r;
  logic         bad;

  // One multiplier step: acc <- (2*acc + w[cnt]*a) mod N, all in W+1 bits.
  always_comb begin
    a        = (state == MUL1) ? e_q : r_q;
    t1       = {acc, 1'b0};
    t1r      = (t1 >= NX) ? t1 - NX : t1;
    t2       = w_q[cnt] ? t1r + {1'b0, a} : t1r;
    t2r      = (t2 >= NX) ? t2 - NX : t2;
    acc_next = t2r[W-1:0];
  end

  // e < 2^W < 2N, so a single conditional subtraction fully reduces it.
  always_comb begin
    e_red = (e_q >= N) ? e_q - N : e_q;
    bad   = (r_q == '0) || (r_q >= N) || (w_q == '0) || (w_q >= N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      u1    <= '0;
      u2    <= '0;
      e_q   <= '0;
      r_q   <= '0;
      w_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            e_q   <= e;
            r_q   <= r;
            w_q   <= w;
            err   <= 1'b0;
            u1    <= '0;
            u2    <= '0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          e_q <= e_red;
          if (bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc   <= '0;
            cnt   <= CW'(W - 1);
            state <= MUL1;
          end
        end
        MUL1: begin
          if (cnt == '0) begin
            u1    <= acc_next;
            acc   <= '0;
            cnt   <= CW'(W - 1);
            state <= MUL2;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
          end
        end
        MUL2: begin
          if (cnt == '0) begin
            u2    <= acc_next;
            acc   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
